instruction_prefetch_queue: RTL
===============================

Name: instruction_prefetch_queue

Overview:
- Parametrised successor to the single-register instruction fetch path.
- Keeps instruction reads running ahead of the multi-cycle core. Buffered instructions and their PCs sit in a DEPTH-entry FIFO.
- The core pops one instruction per accepted handshake and redirects fetch with a flush on taken branches and jumps.
- Sits between the memory read port and the instruction decoder.

Parameters:
- DATA_WIDTH, 32, address and memory read data width.
- INSTRUCTION_WIDTH, 32, stored instruction width (≤ DATA_WIDTH); PC increments by INSTRUCTION_WIDTH/8.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- memoryReadValid  input  1  memory returns read data this cycle for the outstanding request.
- memoryDataRead  input  DATA_WIDTH  read data; low INSTRUCTION_WIDTH bits hold the instruction.
- fetchRequest  output  1  read request; held high until memoryReadValid.
- fetchAddress  output  DATA_WIDTH  address of the outstanding or next request.
- flush  input  1  redirect fetch: discard all buffered and in-flight instructions.
- flushPC  input  DATA_WIDTH  new fetch address when flush=1; low log2(INSTRUCTION_WIDTH/8) bits forced to 0.
- instReady  input  1  core accepts the head instruction this cycle.
- instValid  output  1  FIFO non-empty.
- instOut  output  INSTRUCTION_WIDTH  head instruction.
- instPC  output  DATA_WIDTH  address the head instruction was fetched from.
- count  output  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, fetchPC=RESET_PC, count=0, rd/wr pointers=0, all storage cleared.
  - fetchRequest=0, fetchAddress=RESET_PC, instValid=0, instOut=0, instPC=0.
  - Reset mid-request drops the request. A later memoryReadValid in IDLE is ignored.
- State machine:
  - IDLE: if no flush and (count − pop) < DEPTH, go to WAIT next cycle; fetchRequest=1 there.
  - WAIT: fetchRequest=1; fetchAddress=fetchPC, stable until memoryReadValid.
    - On valid, no flush: push {memoryDataRead[INSTRUCTION_WIDTH-1:0], fetchPC}, fetchPC += INSTRUCTION_WIDTH/8.
    - Then stay in WAIT (back-to-back fetch) if space remains after this cycle's push/pop; otherwise go to IDLE.
  - DISCARD: entered when flush arrives in WAIT without memoryReadValid.
    - fetchRequest stays 1 with the old address until memoryReadValid; that data is dropped; then go to IDLE.
- Space check counts the entry being pushed, so an outstanding request always has a free slot; overflow is impossible.
- Peak throughput is one instruction per cycle when memory returns valid every cycle.
- Latency: a pushed entry is visible (instValid=1) the cycle after memoryReadValid. First fetch after reset: fetchRequest rises 1 cycle after reset release.
- FIFO:
  - Pop occurs when instReady && instValid. instReady with empty FIFO is ignored.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - Pointers wrap modulo DEPTH.
  - instOut/instPC come straight from head storage, with no extra register stage.
- Flush (highest priority):
  - count←0, pointers←0, fetchPC←flushPC (aligned).
  - Any push or pop in the same cycle is cancelled; instValid=0 next cycle.
  - From WAIT with memoryReadValid in the same cycle: data dropped, go to IDLE.
  - From WAIT without valid: go to DISCARD.
  - From DISCARD: stay in DISCARD (unless valid arrives the same cycle, then go to IDLE).
  - From IDLE: stay in IDLE.
  - The first post-flush request uses flushPC.
- Arithmetic: fetchPC addition wraps modulo 2^DATA_WIDTH. No misalignment error is reported.

Test Plan:
- Reset release, RESET_PC=0, memoryReadValid every cycle, instReady=0 → requests to 0x0,0x4,0x8,0xC. count reaches 4 and fetchRequest drops; instPC=0x0, instOut = word at 0x0.
- FIFO full (DEPTH=4), instReady=1 for one cycle → count 4→3. A new request to 0x10 issues and is pushed; count returns to 4. Pop order preserves PCs 0x4,0x8,0xC,0x10.
- Memory returns valid 3 cycles after each request, instReady held 1 → fetchAddress constant during the wait; instructions emerge in order with count ≤ 1.
- Flush with flushPC=0x103 while WAIT at 0x8 and no valid → DISCARD. Response for 0x8 is dropped, count=0, next request to 0x100, instPC=0x100 first.
- Flush and memoryReadValid in the same cycle with instReady=1 and count=2 → no push, no pop; count=0 and instValid=0 next cycle; next request uses flushPC.
- Assert reset low during WAIT, then release → fetchRequest=0 immediately, outputs at reset values. Stray memoryReadValid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues memory reads ahead of the core and buffers
// fetched instructions with their PCs in a DEPTH-entry FIFO.
//
// state   | meaning
// IDLE    | no request outstanding; waiting for a free slot or a flush to settle
// WAIT    | request outstanding at fetchPC; response is pushed on arrival
// DISCARD | request outstanding from before a flush; its response is dropped
module instruction_prefetch_queue #(
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int DEPTH             = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memoryReadValid,
    input  logic [DATA_WIDTH-1:0]        memoryDataRead,
    output logic                         fetchRequest,
    output logic [DATA_WIDTH-1:0]        fetchAddress,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        flushPC,
    input  logic                         instReady,
    output logic                         instValid,
    output logic [INSTRUCTION_WIDTH-1:0] instOut,
    output logic [DATA_WIDTH-1:0]        instPC,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int INST_BYTES = INSTRUCTION_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(INST_BYTES);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(INST_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK =
        ~((DATA_WIDTH'(1) << ALIGN_BITS) - DATA_WIDTH'(1));
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } stateT;

    stateT                        state;
    stateT                        nextState;
    logic [DATA_WIDTH-1:0]        fetchPC;
    logic [DATA_WIDTH-1:0]        discardAddr;
    logic [PTR_W-1:0]             rdPtr;
    logic [PTR_W-1:0]             wrPtr;
    logic [INSTRUCTION_WIDTH-1:0] instMem [DEPTH];
    logic [DATA_WIDTH-1:0]        pcMem   [DEPTH];
    logic                         push;
    logic                         pop;
    logic [CNT_W:0]               countAfter;
    logic [CNT_W:0]               countLessPop;

    // Flush cancels both sides of the FIFO in the cycle it is seen.
    assign instValid    = (count != '0);
    assign push         = (state == WAIT) && memoryReadValid && !flush;
    assign pop          = instReady && instValid && !flush;
    assign countLessPop = {1'b0, count} - (CNT_W + 1)'(pop);
    assign countAfter   = countLessPop + (CNT_W + 1)'(push);
    assign instOut      = instMem[rdPtr];
    assign instPC       = pcMem[rdPtr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!flush && (countLessPop < DEPTH_EXT)) nextState = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    nextState = memoryReadValid ? IDLE : DISCARD;
                end else if (memoryReadValid && (countAfter >= DEPTH_EXT)) begin
                    nextState = IDLE;
                end
            end
            DISCARD: begin
                if (memoryReadValid) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        fetchRequest = (state != IDLE);
        fetchAddress = (state == DISCARD) ? discardAddr : fetchPC;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchPC     <= RESET_PC;
            discardAddr <= '0;
            count       <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
        end else if (flush) begin
            fetchPC <= flushPC & ALIGN_MASK;
            count   <= '0;
            rdPtr   <= '0;
            wrPtr   <= '0;
            // The in-flight request keeps its address on the bus until answered.
            if (state == WAIT && !memoryReadValid) discardAddr <= fetchPC;
        end else begin
            count <= countAfter[CNT_W-1:0];
            if (push) begin
                fetchPC <= fetchPC + PC_STEP;
                wrPtr   <= wrPtr + PTR_W'(1);
            end
            if (pop) rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else if (push) begin
            instMem[wrPtr] <= memoryDataRead[INSTRUCTION_WIDTH-1:0];
            pcMem[wrPtr]   <= fetchPC;
        end
    end

endmodule
